sad_engine_par: RTL and testbench



---
 rtl/sad_pkg.sv | 33 +++
 rtl/sad_lane_pe.sv | 28 ++
 rtl/sad_engine_par.sv | 212 +++++++++++++++++++++
 tb/tb_sad_engine_par.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared types and width helpers for the parallel SAD/SSD engine.
// Holds the FSM encoding, mode constants and the drain depth of the 3-stage pipe.
package sad_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic MODE_SAD = 1'b0;
    localparam logic MODE_SSD = 1'b1;

    localparam int DRAIN_CYCLES = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int lane_sum_w(input int d_width, input int lanes);
        return 2 * d_width + clog2(lanes);
    endfunction

endpackage

// File: rtl/sad_lane_pe.sv
// One lane: |A-B| or (A-B)^2 of a pixel pair, purely combinational.
// Zero latency; the caller registers the result into P1.
module sad_lane_pe
    import sad_pkg::*;
#(
    parameter int D_WIDTH = 8
) (
    input  logic [D_WIDTH-1:0]   a,
    input  logic [D_WIDTH-1:0]   b,
    input  logic                 mode,
    output logic [2*D_WIDTH-1:0] res
);

    logic signed [D_WIDTH:0] diff;
    logic signed [D_WIDTH:0] abs_diff;
    logic [2*D_WIDTH-1:0]    mag_ext;
    logic [2*D_WIDTH-1:0]    sq;

    always_comb begin
        diff     = $signed({1'b0, a}) - $signed({1'b0, b});
        abs_diff = diff[D_WIDTH] ? -diff : diff;
        // |diff| never exceeds 2^D_WIDTH-1, so the sign bit of abs_diff is always 0
        mag_ext  = {{(D_WIDTH-1){1'b0}}, abs_diff};
        sq       = mag_ext * mag_ext;
        res      = (mode == MODE_SSD) ? sq : mag_ext;
    end

endmodule

// File: rtl/sad_engine_par.sv
// Multi-lane SAD/SSD engine: one saturating distortion sum per block written to the result SRAM.
// Word-to-accumulator latency 4 cycles (SRAM, P1, P2, acc); no backpressure, SRAMs are fixed latency.
module sad_engine_par
    import sad_pkg::*;
#(
    parameter int D_WIDTH    = 8,
    parameter int LANES      = 4,
    parameter int BLK_PIXELS = 256,
    parameter int NUM_BLKS   = 128,
    parameter int A_WIDTH    = 15,
    parameter int C_WIDTH    = 7,
    parameter int SAD_WIDTH  = 32
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Go,
    input  logic                       Mode,
    output logic [A_WIDTH-1:0]         A_Addr,
    input  logic [LANES*D_WIDTH-1:0]   A_Data,
    output logic [A_WIDTH-1:0]         B_Addr,
    input  logic [LANES*D_WIDTH-1:0]   B_Data,
    output logic                       I_En,
    output logic                       I_RW,
    output logic [C_WIDTH-1:0]         C_Addr,
    output logic                       O_En,
    output logic                       O_RW,
    output logic [SAD_WIDTH-1:0]       SAD_Out,
    output logic                       Busy,
    output logic                       Done
);

    localparam int WORDS  = BLK_PIXELS / LANES;
    localparam int W_CW   = (clog2(WORDS) > 0) ? clog2(WORDS) : 1;
    localparam int DR_CW  = (clog2(DRAIN_CYCLES) > 0) ? clog2(DRAIN_CYCLES) : 1;
    localparam int PROD_W = 2 * D_WIDTH;
    localparam int LSUM_W = lane_sum_w(D_WIDTH, LANES);
    localparam int ADD_W  = ((SAD_WIDTH > LSUM_W) ? SAD_WIDTH : LSUM_W) + 1;

    localparam logic [W_CW-1:0]      LAST_WORD  = W_CW'(WORDS - 1);
    localparam logic [C_WIDTH-1:0]   LAST_BLK   = C_WIDTH'(NUM_BLKS - 1);
    localparam logic [DR_CW-1:0]     LAST_DRAIN = DR_CW'(DRAIN_CYCLES - 1);
    localparam logic [SAD_WIDTH-1:0] SAT_MAX    = {SAD_WIDTH{1'b1}};

    state_t               state;
    state_t               state_nx;
    logic                 mode_q;
    logic [A_WIDTH-1:0]   addr_q;
    logic [W_CW-1:0]      word_q;
    logic [C_WIDTH-1:0]   blk_q;
    logic [DR_CW-1:0]     drain_q;
    logic [SAD_WIDTH-1:0] acc_q;
    logic [SAD_WIDTH-1:0] acc_sat;
    logic [ADD_W-1:0]     acc_add;
    logic                 start;

    logic                 vld0;
    logic                 vld1;
    logic                 vld2;
    logic [PROD_W-1:0]    pe_res [LANES];
    logic [PROD_W-1:0]    p1_q   [LANES];
    logic [LSUM_W-1:0]    tree_sum;
    logic [LSUM_W-1:0]    p2_q;

    assign start  = (state == S_IDLE) && Go;
    assign A_Addr = addr_q;
    assign B_Addr = addr_q;
    assign I_RW   = 1'b0;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        I_En     = 1'b0;
        O_En     = 1'b0;
        O_RW     = 1'b0;
        C_Addr   = '0;
        SAD_Out  = '0;
        Busy     = 1'b1;
        Done     = 1'b0;
        case (state)
            S_IDLE: begin
                Busy = 1'b0;
                if (Go) begin
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                I_En = 1'b1;
                if (word_q == LAST_WORD) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                O_En     = 1'b1;
                O_RW     = 1'b1;
                C_Addr   = blk_q;
                SAD_Out  = acc_q;
                state_nx = (blk_q == LAST_BLK) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                Done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Blocks are contiguous in the operand SRAMs, so one free-running address covers b*WORDS+w.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mode_q  <= MODE_SAD;
            addr_q  <= '0;
            word_q  <= '0;
            blk_q   <= '0;
            drain_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Go) begin
                        mode_q  <= Mode;
                        addr_q  <= '0;
                        word_q  <= '0;
                        blk_q   <= '0;
                        drain_q <= '0;
                    end
                end
                S_FETCH: begin
                    addr_q <= addr_q + A_WIDTH'(1);
                    word_q <= (word_q == LAST_WORD) ? '0 : word_q + W_CW'(1);
                end
                S_DRAIN: begin
                    drain_q <= (drain_q == LAST_DRAIN) ? '0 : drain_q + DR_CW'(1);
                end
                S_WRITE: begin
                    if (blk_q != LAST_BLK) begin
                        blk_q <= blk_q + C_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sad_lane_pe #(
            .D_WIDTH (D_WIDTH)
        ) u_pe (
            .a    (A_Data[g*D_WIDTH +: D_WIDTH]),
            .b    (B_Data[g*D_WIDTH +: D_WIDTH]),
            .mode (mode_q),
            .res  (pe_res[g])
        );
    end

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            tree_sum = tree_sum + LSUM_W'(p1_q[i]);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            vld0 <= 1'b0;
            vld1 <= 1'b0;
            vld2 <= 1'b0;
            p2_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                p1_q[i] <= '0;
            end
        end else begin
            vld0 <= (state == S_FETCH);
            vld1 <= vld0;
            vld2 <= vld1;
            p2_q <= tree_sum;
            for (int i = 0; i < LANES; i++) begin
                p1_q[i] <= pe_res[i];
            end
        end
    end

    // Adding a non-negative term to SAT_MAX clamps back to SAT_MAX, so saturation is sticky.
    always_comb begin
        acc_add = ADD_W'(acc_q) + ADD_W'(p2_q);
        acc_sat = (acc_add > ADD_W'(SAT_MAX)) ? SAT_MAX : acc_add[SAD_WIDTH-1:0];
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            acc_q <= '0;
        end else if (start || (state == S_WRITE)) begin
            acc_q <= '0;
        end else if (vld2) begin
            acc_q <= acc_sat;
        end
    end

endmodule

// File: tb/tb_sad_engine_par.sv
// Bench for sad_engine_par: SRAM models, a per-block pixel-loop reference and a per-cycle checker.
// A second small instance with a 16-bit result exercises saturation.
module tb_sad_engine_par;

    localparam int DW    = 8;
    localparam int LN    = 4;
    localparam int BP    = 256;
    localparam int WORDS = BP / LN;
    localparam int NB    = 128;
    localparam int AW    = 15;
    localparam int CW    = 7;
    localparam int SW    = 32;
    localparam int NB16  = 4;
    localparam int AW16  = 8;
    localparam int CW16  = 2;
    localparam int SW16  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              go, mode, go16, mode16;
    logic [AW-1:0]     a_addr, b_addr;
    logic [LN*DW-1:0]  a_data = '0, b_data = '0;
    logic              i_en, i_rw, o_en, o_rw, busy, done;
    logic [CW-1:0]     c_addr;
    logic [SW-1:0]     sad_out;

    logic [AW16-1:0]   a_addr16, b_addr16;
    logic [LN*DW-1:0]  a_data16 = '0, b_data16 = '0;
    logic              i_en16, i_rw16, o_en16, o_rw16, busy16, done16;
    logic [CW16-1:0]   c_addr16;
    logic [SW16-1:0]   sad_out16;

    sad_engine_par u_dut (
        .Clk(clk), .Rst(rst), .Go(go), .Mode(mode),
        .A_Addr(a_addr), .A_Data(a_data), .B_Addr(b_addr), .B_Data(b_data),
        .I_En(i_en), .I_RW(i_rw), .C_Addr(c_addr), .O_En(o_en), .O_RW(o_rw),
        .SAD_Out(sad_out), .Busy(busy), .Done(done)
    );

    sad_engine_par #(
        .NUM_BLKS(NB16), .A_WIDTH(AW16), .C_WIDTH(CW16), .SAD_WIDTH(SW16)
    ) u_dut16 (
        .Clk(clk), .Rst(rst), .Go(go16), .Mode(mode16),
        .A_Addr(a_addr16), .A_Data(a_data16), .B_Addr(b_addr16), .B_Data(b_data16),
        .I_En(i_en16), .I_RW(i_rw16), .C_Addr(c_addr16), .O_En(o_en16), .O_RW(o_rw16),
        .SAD_Out(sad_out16), .Busy(busy16), .Done(done16)
    );

    logic [LN*DW-1:0] mem_a [0:(1<<AW)-1];
    logic [LN*DW-1:0] mem_b [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (i_en) begin
            a_data <= mem_a[a_addr];
            b_data <= mem_b[b_addr];
        end
        if (i_en16) begin
            a_data16 <= mem_a[a_addr16];
            b_data16 <= mem_b[b_addr16];
        end
    end

    int tests = 0;
    int fails = 0;
    int exp_addr, exp_blk, wr_cnt, done_cnt, wr16_cnt, exp_blk16;
    bit cur_mode, cur_mode16;
    bit wrote [0:NB-1];

    task automatic chk(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: walk every pixel of block b straight from the SRAM images.
    function automatic longint exp_block(input int b, input bit m, input int satw);
        longint s, d, cap;
        logic [LN*DW-1:0] wa, wb;
        s = 0;
        for (int p = 0; p < BP; p++) begin
            wa = mem_a[b*WORDS + p/LN];
            wb = mem_b[b*WORDS + p/LN];
            d  = longint'(wa[(p%LN)*DW +: DW]) - longint'(wb[(p%LN)*DW +: DW]);
            s += m ? d*d : ((d < 0) ? -d : d);
        end
        cap = (longint'(1) << satw) - 1;
        return (s > cap) ? cap : s;
    endfunction

    task automatic fill(input int kind);
        for (int w = 0; w < NB*WORDS; w++) begin
            case (kind)
                0: begin mem_a[w] = $urandom; mem_b[w] = mem_a[w]; end
                1: begin mem_a[w] = 32'hFFFF_FFFF; mem_b[w] = 32'h0; end
                default: begin mem_a[w] = $urandom; mem_b[w] = $urandom; end
            endcase
        end
    endtask

    task automatic clear_tracking();
        exp_addr = 0; exp_blk = 0; wr_cnt = 0; done_cnt = 0;
        for (int i = 0; i < NB; i++) wrote[i] = 1'b0;
    endtask

    function automatic int written_from(input int first);
        int n = 0;
        for (int i = first; i < NB; i++) n += int'(wrote[i]);
        return n;
    endfunction

    always @(negedge clk) begin
        if (i_en) begin
            chk("a_addr", longint'(a_addr), longint'(exp_addr));
            chk("b_addr", longint'(b_addr), longint'(exp_addr));
            chk("i_rw", longint'(i_rw), 0);
            exp_addr++;
        end
        if (o_en) begin
            chk("o_rw", longint'(o_rw), 1);
            chk("busy_on_write", longint'(busy), 1);
            chk("c_addr", longint'(c_addr), longint'(exp_blk));
            chk("sad_out", longint'(sad_out), exp_block(int'(c_addr), cur_mode, SW));
            wrote[c_addr] = 1'b1;
            wr_cnt++;
            exp_blk++;
        end
        if (done) done_cnt++;
        if (o_en16) begin
            chk("c_addr16", longint'(c_addr16), longint'(exp_blk16));
            chk("sad_out16", longint'(sad_out16), exp_block(int'(c_addr16), cur_mode16, SW16));
            wr16_cnt++;
            exp_blk16++;
        end
    end

    // edges counts rising edges from the one that samples Go (edge 1) to the one starting the Done cycle.
    task automatic run(input bit m, input int stray_at, input int flip_at, output int edges);
        int cnt = 0;
        @(negedge clk);
        clear_tracking();
        cur_mode = m; mode = m; go = 1'b1;
        edges = -1;
        while (cnt < 20000) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (cnt == 1) begin
                go = 1'b0;
                chk("busy_after_go", longint'(busy), 1);
            end
            if (cnt == stray_at) go = 1'b1;
            if (cnt == stray_at + 1) go = 1'b0;
            if (cnt == flip_at) mode = ~m;
            if (done) begin
                edges = cnt;
                break;
            end
        end
        repeat (30) @(negedge clk);
        chk("write_count", longint'(wr_cnt), NB);
        chk("done_pulses", longint'(done_cnt), 1);
        chk("busy_idle", longint'(busy), 0);
        chk("all_blocks_written", longint'(written_from(0)), NB);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_i_en"}, longint'(i_en), 0);
        chk({tag, "_o_en"}, longint'(o_en), 0);
        chk({tag, "_o_rw"}, longint'(o_rw), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_sad_out"}, longint'(sad_out), 0);
        chk({tag, "_a_addr"}, longint'(a_addr), 0);
        chk({tag, "_c_addr"}, longint'(c_addr), 0);
    endtask

    initial begin
        int e, k;
        rst = 1'b0; go = 1'b0; mode = 1'b0; go16 = 1'b0; mode16 = 1'b0;
        exp_blk16 = 0; wr16_cnt = 0;
        clear_tracking();
        fill(1);
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Hand-computed anchors for the reference model.
        chk("pin_sad_ff00", exp_block(0, 1'b0, SW), 64'h0000_FF00);
        chk("pin_ssd_ff00", exp_block(7, 1'b1, SW), 64'h00FE_0100);
        chk("pin_ssd_sat16", exp_block(0, 1'b1, SW16), 64'hFFFF);
        fill(0);
        chk("pin_identical", exp_block(3, 1'b0, SW), 0);

        // Identical operands, SAD.
        run(1'b0, -1, -1, e);
        chk("t1_done_edges", longint'(e), NB*(WORDS+4)+1);

        // All-0xFF vs all-0x00 SAD with a stray Go mid-run.
        fill(1);
        run(1'b0, 100, -1, e);
        chk("t2_done_edges", longint'(e), NB*(WORDS+4)+1);

        // Same data in SSD; Mode toggled while busy must not matter.
        run(1'b1, -1, 50, e);
        chk("t3_done_edges", longint'(e), NB*(WORDS+4)+1);
        mode = 1'b0;

        // 16-bit result instance saturates.
        @(negedge clk);
        cur_mode16 = 1'b1; mode16 = 1'b1; go16 = 1'b1; exp_blk16 = 0; wr16_cnt = 0;
        @(negedge clk);
        go16 = 1'b0;
        k = 0;
        while (!done16 && k < 2000) begin @(negedge clk); k++; end
        chk("t4_done16_seen", longint'(done16), 1);
        repeat (5) @(negedge clk);
        chk("t4_write_count16", longint'(wr16_cnt), NB16);

        // Asynchronous reset in the middle of block 5.
        fill(2);
        @(negedge clk);
        clear_tracking();
        cur_mode = 1'b1; mode = 1'b1; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        k = 0;
        while (wr_cnt < 5 && k < 5000) begin @(negedge clk); k++; end
        repeat (10) @(negedge clk);
        chk("t5_pre_reset_fetch", longint'(i_en), 1);
        #2 rst = 1'b0;
        #1 check_outputs_zero("t5_async");
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5_writes_before_abort", longint'(wr_cnt), 5);
        chk("t5_blocks_5_up_unwritten", longint'(written_from(5)), 0);
        chk("t5_idle_after_reset", longint'(busy), 0);

        run(1'b0, -1, -1, e);
        chk("t5_rerun_done_edges", longint'(e), NB*(WORDS+4)+1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
